// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fsub latency, op encoding, IEEE-754 single field layout.
package fpu_pkg;

  localparam int FSUB_LAT = 3;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam logic [7:0] EXP_MAX = 8'd255;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } f32_t;

  // The pipe only subtracts; an add is a subtract of the negated b operand.
  function automatic logic [31:0] op_operand_b(input logic op, input logic [31:0] b);
    f32_t f;
    f = b;
    f.sign = b[SIGN_BIT] ^ (op == OP_ADD);
    return f;
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// In-order circular response FIFO with occupancy count and synchronous clear.
module fpu_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 38,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_fire;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_fire = rd_en && (count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (rd_fire) rd_ptr <= bump(rd_ptr);
      case ({wr_en, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is a plain RAM; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (rstn && !clr && wr_en)
      assert (count != CW'(DEPTH)) else $error("fpu_rsp_fifo: write while full");
  end

endmodule

// File: rtl/fsub_issue_ctrl.sv
// Issue/collect controller for the fixed-latency fsub pipe: credit-gated issue,
// in-flight valid/tag shift register, in-order response FIFO and overflow sticky.
module fsub_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT = FSUB_LAT,
  parameter int TAGW = 5,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [TAGW-1:0] req_tag,
  input  logic            flush,
  output logic [31:0]     pipe_x1,
  output logic [31:0]     pipe_x2,
  input  logic [31:0]     pipe_y,
  input  logic            pipe_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_ovf,
  output logic [TAGW-1:0] rsp_tag,
  output logic            ovf_sticky,
  input  logic            ovf_clr,
  output logic            idle
);

  localparam int EW = 1 + TAGW + 32;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = $clog2(DEPTH + LAT + 2);

  logic [LAT:0]    sv;
  logic [TAGW-1:0] st [LAT+1];
  logic [CW-1:0]   count;
  logic [UW-1:0]   used;
  logic [EW-1:0]   head;
  logic            accept;
  logic            capture;

  assign accept  = req_valid && req_ready;
  assign capture = sv[LAT];

  // Every in-flight slot already owns a FIFO entry, so the pipe never overruns it.
  always_comb begin
    used = UW'(count);
    for (int i = 0; i <= LAT; i++) used = used + UW'(sv[i]);
  end

  assign req_ready = !flush && (used < UW'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sv      <= '0;
      pipe_x1 <= '0;
      pipe_x2 <= '0;
      for (int i = 0; i <= LAT; i++) st[i] <= '0;
    end else begin
      sv    <= flush ? '0 : {sv[LAT-1:0], accept};
      st[0] <= req_tag;
      for (int i = 0; i < LAT; i++) st[i+1] <= st[i];
      if (accept) begin
        pipe_x1 <= req_a;
        pipe_x2 <= op_operand_b(req_op, req_b);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_sticky <= 1'b0;
    else if (capture && pipe_ovf && !flush) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

  fpu_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (flush),
    .wr_en   (capture),
    .wr_data ({pipe_ovf, st[LAT], pipe_y}),
    .rd_en   (rsp_ready),
    .rd_data (head),
    .count   (count)
  );

  assign rsp_valid = (count != '0);
  assign {rsp_ovf, rsp_tag, rsp_data} = head;
  assign idle = (sv == '0) && (count == '0);

endmodule
